// File: rtl/forex_edge_ingress.sv
// forex_edge_ingress: Avalon-MM edge-update queue and run sequencer for the graph engine
// Software stages (src,dst) at addr0 and pushes {src,dst,weight} at addr1 into a FIFO.
// The FIFO drains to the engine over upd_valid/upd_ready; afterwards an engine restart
// pulse (eng_reset) starts a run, and eng_done completes it and bumps run_count.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   chipselect, write, read         Avalon strobes
//   address[2:0], writedata[31:0]   register index / write data
//   readdata[31:0]                  registered read data (valid 1 cycle after read)
//   upd_valid, upd_src, upd_dst,
//   upd_w, upd_ready                edge-update stream to the engine (head of FIFO)
//   eng_reset                       engine restart pulse
//   eng_done                        engine run complete
//   irq                             completion interrupt
// Optional: define FOREX_IRQ_EN to enable the masked, registered completion interrupt.
module forex_edge_ingress #(
  parameter int VTX_W = 4,
  parameter int WT_W  = 32,
  parameter int DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                chipselect,
  input  logic                write,
  input  logic                read,
  input  logic [2:0]          address,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic                upd_valid,
  output logic [VTX_W-1:0]    upd_src,
  output logic [VTX_W-1:0]    upd_dst,
  output logic [WT_W-1:0]     upd_w,
  input  logic                upd_ready,
  output logic                eng_reset,
  input  logic                eng_done,
  output logic                irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 * VTX_W + WT_W;
  typedef enum logic [1:0] {IDLE, DRAIN, RESTART, RUN} state_t;
  state_t state, state_nx;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count, count_nx;
  logic [VTX_W-1:0] stg_src, stg_dst;
  logic auto_run, run_pending, overflow, done_sticky, irq_mask, rst_q;
  logic [31:0] run_count, rd_val;
  logic wr_en, ctl, push_req, full, push, pop, run_done;
  assign wr_en    = chipselect && write;
  assign ctl      = wr_en && address == 3'd2;
  assign push_req = wr_en && address == 3'd1;
  assign full     = count == (AW + 1)'(DEPTH);
  assign push     = push_req && !full;
  assign pop      = upd_valid && upd_ready;
  assign run_done = state == RUN && eng_done;
  assign count_nx = count + (AW + 1)'(push) - (AW + 1)'(pop);
  assign {upd_src, upd_dst, upd_w} = mem[rp];
  // DRAIN leaves as soon as the FIFO will be empty after this cycle's pop,
  // so upd_valid never shows a dead cycle at the end of a drain.
  always_comb begin
    state_nx  = state;
    upd_valid = 1'b0;
    eng_reset = reset || rst_q;
    case (state)
      IDLE:    state_nx = count != 0 ? DRAIN : run_pending ? RESTART : IDLE;
      DRAIN: begin
        upd_valid = count != 0;
        if (count_nx == 0) state_nx = (auto_run || run_pending) ? RESTART : IDLE;
      end
      RESTART: begin
        eng_reset = 1'b1;
        state_nx  = RUN;
      end
      RUN:     state_nx = eng_done ? IDLE : RUN;
      default: state_nx = IDLE;
    endcase
  end
  assign rd_val = address == 3'd3 ? {10'd0, run_pending, done_sticky, state != IDLE, overflow,
                                     full, count == 0, 16'(count)} :
                  address == 3'd4 ? run_count :
                  address == 3'd2 ? {28'd0, irq_mask, 2'd0, auto_run} : 32'd0;
  always_ff @(posedge clk)
    if (push) mem[wp] <= {stg_src, stg_dst, writedata[WT_W-1:0]};
  // Later assignments win: an overflow on the clearing write stays set, and a
  // run_req coinciding with the completing eng_done keeps run_pending for another run.
  always_ff @(posedge clk) begin
    rst_q <= reset;
    if (reset) begin
      state       <= IDLE;
      wp          <= '0;
      rp          <= '0;
      count       <= '0;
      stg_src     <= '0;
      stg_dst     <= '0;
      auto_run    <= 1'b0;
      run_pending <= 1'b0;
      overflow    <= 1'b0;
      done_sticky <= 1'b0;
      run_count   <= '0;
      readdata    <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (wr_en && address == 3'd0) {stg_src, stg_dst} <= writedata[2*VTX_W-1:0];
      if (ctl) auto_run <= writedata[0];
      if (ctl && writedata[2]) {overflow, done_sticky} <= 2'b00;
      if (push_req && full) overflow <= 1'b1;
      if (run_done) begin
        run_count   <= run_count + 1'b1;
        done_sticky <= 1'b1;
        run_pending <= 1'b0;
      end
      if (ctl && writedata[1]) run_pending <= 1'b1;
      if (chipselect && read) readdata <= rd_val;
    end
  end
`ifdef FOREX_IRQ_EN
  always_ff @(posedge clk)
    if (reset) {irq_mask, irq} <= 2'b00;
    else begin
      if (ctl) irq_mask <= writedata[3];
      irq <= done_sticky && irq_mask;
    end
`else
  assign irq_mask = 1'b0;
  assign irq      = 1'b0;
`endif
endmodule

// File: tb/tb_forex_edge_ingress.sv
// tb_forex_edge_ingress: randomized self-checking bench with a queue scoreboard
module tb_forex_edge_ingress;
  localparam int DEPTH = 8;
`ifdef FOREX_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  logic clk = 0, reset = 1, chipselect = 0, write = 0, read = 0, eng_done = 0;
  logic [2:0] address = 0;
  logic [31:0] writedata = 0, readdata, upd_w;
  logic upd_valid, upd_ready, eng_reset, irq;
  logic [3:0] upd_src, upd_dst;
  logic rdy_force = 0, rdy_rnd = 0, rnd_mode = 0;
  int errors = 0, checks = 0, pops = 0, vcyc = 0, er_cnt = 0;
  logic [39:0] exp_q[$];
  assign upd_ready = rnd_mode ? rdy_rnd : rdy_force;
  forex_edge_ingress dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .upd_valid(upd_valid), .upd_src(upd_src), .upd_dst(upd_dst), .upd_w(upd_w),
    .upd_ready(upd_ready), .eng_reset(eng_reset), .eng_done(eng_done), .irq(irq)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1 rdy_rnd = 1'($urandom);
  end
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (!reset) begin
      if (upd_valid) vcyc++;
      if (eng_reset) er_cnt++;
      if (upd_valid && upd_ready) begin
        pops++;
        if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
        else chk("pop_data", {upd_src, upd_dst, upd_w}, exp_q.pop_front());
      end
    end
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(logic [2:0] a, logic [31:0] d);
    chipselect = 1; write = 1; address = a; writedata = d;
    cyc(1);
    chipselect = 0; write = 0;
  endtask
  task automatic rd(logic [2:0] a, output logic [31:0] d);
    chipselect = 1; read = 1; address = a;
    cyc(1);
    chipselect = 0; read = 0;
    d = readdata;
  endtask
  task automatic chk_rd(string tag, logic [2:0] a, logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask
  task automatic push(logic [3:0] s, logic [3:0] d, logic [31:0] w);
    wr(0, {24'd0, s, d});
    wr(1, w);
    if (exp_q.size() < DEPTH) exp_q.push_back({s, d, w});
  endtask
  task automatic push_rnd();
    push(4'($urandom), 4'($urandom), $urandom);
  endtask
  task automatic wait_er(int n);
    for (int i = 0; i < 60 && er_cnt < n; i++) cyc(1);
    chk("er_wait", er_cnt, n);
  endtask
  task automatic done_pulse();
    eng_done = 1;
    cyc(1);
    eng_done = 0;
  endtask
  task automatic do_reset();
    reset = 1;
    cyc(2);
    chk("rst_valid", upd_valid, 0);
    chk("rst_engrst", eng_reset, 1);
    reset = 0;
    #2;
    chk("post_engrst", eng_reset, 1);
    cyc(1);
    chk("post_engrst_off", eng_reset, 0);
    exp_q.delete();
    er_cnt = 0; vcyc = 0; pops = 0;
  endtask
  initial begin
    int v0;
    do_reset();
    chk("rd_rst", readdata, 0);
    chk("irq_rst", irq, 0);
    chk_rd("st_rst", 3, 32'h10000);
    chk_rd("rc_rst", 4, 0);
    rdy_force = 1;
    push(4'd2, 4'd3, 32'hFFFFFF38);
    cyc(5);
    chk("t1_pops", pops, 1);
    chk("t1_vcyc", vcyc, 1);
    chk("t1_er", er_cnt, 0);
    chk_rd("t1_st", 3, 32'h10000);
    chk_rd("t1_rc", 4, 0);
    rdy_force = 0;
    for (int i = 0; i < 9; i++) push_rnd();
    chk_rd("t2_st", 3, 32'hE0008);
    rdy_force = 1;
    cyc(12);
    chk("t2_pops", pops, 9);
    chk("t2_q", exp_q.size(), 0);
    chk_rd("t2_ovf", 3, 32'h50000);
    wr(2, 4);
    chk_rd("t2_clr", 3, 32'h10000);
    chk("t2_er", er_cnt, 0);
    rdy_force = 0;
    wr(2, 9);
    chk_rd("ctl_rb", 2, IRQ ? 32'd9 : 32'd1);
    for (int i = 0; i < 3; i++) push_rnd();
    rdy_force = 1;
    wait_er(1);
    chk("t3_pops", pops, 12);
    cyc(3);
    v0 = vcyc;
    push_rnd();
    push_rnd();
    chk_rd("t4_st", 3, 32'h80002);
    chk("t4_novalid", vcyc, v0);
    cyc(2);
    done_pulse();
    chk_rd("t4_rc1", 4, 1);
    wait_er(2);
    chk("t4_pops", pops, 14);
    cyc(3);
    done_pulse();
    cyc(2);
    chk_rd("t4_rc2", 4, 2);
    chk_rd("t4_st2", 3, 32'h110000);
    chk("t4_irq", irq, IRQ);
    wr(2, 12);
    cyc(2);
    chk("t5_irq_clr", irq, 0);
    chk_rd("t5_st", 3, 32'h10000);
    done_pulse();
    chk_rd("t5_rc", 4, 2);
    chk("t5_er", er_cnt, 2);
    wr(2, 2);
    chk_rd("t5_pend", 3, 32'h210000);
    wait_er(3);
    cyc(1);
    chk_rd("t5_run", 3, 32'h290000);
    done_pulse();
    chk_rd("t5_rc3", 4, 3);
    chk_rd("t5_st3", 3, 32'h110000);
    wr(2, 2);
    wait_er(4);
    cyc(2);
    eng_done = 1;
    wr(2, 2);
    eng_done = 0;
    wait_er(5);
    chk_rd("t6_rc4", 4, 4);
    cyc(2);
    done_pulse();
    chk_rd("t6_rc5", 4, 5);
    wr(2, 4);
    chk_rd("t6_st", 3, 32'h10000);
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 5);
      rnd_mode = 1;
      for (int i = 0; i < n; i++) push_rnd();
      rnd_mode = 0;
      rdy_force = 1;
      cyc(10);
      chk("rnd_q", exp_q.size(), 0);
    end
    chk_rd("rnd_st", 3, 32'h10000);
    chk("rnd_er", er_cnt, 5);
    rdy_force = 0;
    for (int i = 0; i < 3; i++) push_rnd();
    chk("rm_valid", upd_valid, 1);
    do_reset();
    chk("rm_rd", readdata, 0);
    chk("rm_valid0", upd_valid, 0);
    chk_rd("rm_st", 3, 32'h10000);
    chk_rd("rm_rc", 4, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/forex_edge_ingress.md
Name: forex_edge_ingress

Overview:
Parametrised Avalon-MM front end for the arbitrage graph engine. Software writes (src, dst, weight) edge updates, which are queued in a FIFO and issued to the engine over a valid/ready stream. Once the queue drains, the block restarts an engine run, waits for completion and counts completed runs. It sits between the HPS bridge and the graph engine and replaces the single-register, free-running update/restart loop.

Parameters:
VTX_W, 4, vertex index width in bits (16 currencies); 2*VTX_W must be 32 or less.
WT_W, 32, edge weight width in bits, two's complement; must be 32 or less.
DEPTH, 8, FIFO entries; power of two, 2 or more.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
chipselect  in  1  Avalon select
write  in  1  Avalon write strobe
read  in  1  Avalon read strobe
address  in  3  register index
writedata  in  32  write data
readdata  out  32  registered read data
upd_valid  out  1  edge update available
upd_src  out  VTX_W  update source vertex
upd_dst  out  VTX_W  update destination vertex
upd_w  out  WT_W  update weight
upd_ready  in  1  engine accepts update
eng_reset  out  1  engine restart pulse
eng_done  in  1  engine run complete (pulse or level)
irq  out  1  completion interrupt

Behaviour:
- Clock is clk. Reset is reset, synchronous, active-high.
- Reset state: FIFO empty, all flags 0, run_count=0, readdata=0, upd_valid=0, irq=0, FSM=IDLE. eng_reset=1 while reset is high and for the first cycle after reset deasserts.
- Writes are accepted when chipselect && write:
  - addr0: staging src = writedata[2*VTX_W-1:VTX_W], staging dst = writedata[VTX_W-1:0].
  - addr1: weight = writedata[WT_W-1:0]. Pushes {staging src, staging dst, weight} in the same cycle.
  - addr2: control. bit0 auto_run (held). bit1 run_req, self-clearing; it sets run_pending. bit2 clears overflow and done_sticky. bit3 irq_mask (held).
  - Other addresses: writes ignored.
- Push when full: the push is dropped and overflow is set (sticky). Fullness is evaluated before this cycle's pop, so a push into a full FIFO is dropped even when a pop occurs in the same cycle.
- Reads: readdata is valid 1 cycle after chipselect && read and holds until the next read.
  - addr3 status: [15:0] count, bit16 empty, bit17 full, bit18 overflow, bit19 busy (FSM!=IDLE), bit20 done_sticky, bit21 run_pending.
  - addr4: run_count, 32-bit, wraps from 0xFFFFFFFF to 0.
  - addr2: reads back bit0 and bit3. Other addresses read 0.
- FIFO head drives upd_src/dst/w combinationally. Head values are stable while upd_valid && !upd_ready. A pop occurs on upd_valid && upd_ready.
- FSM:
  - IDLE: if FIFO non-empty, go to DRAIN. Else if run_pending, go to RESTART.
  - DRAIN: upd_valid = !empty. When the FIFO becomes empty after the last pop: if auto_run or run_pending, go to RESTART; otherwise go to IDLE.
  - RESTART: eng_reset=1 for exactly 1 cycle, then go to RUN.
  - RUN: upd_valid=0. Pushes still queue. On eng_done: run_count += 1, done_sticky=1, run_pending=0, go to IDLE.
- upd_valid is 0 outside DRAIN. eng_done outside RUN is ignored.
- A run_req write in the same cycle as the eng_done that completes a run leaves run_pending=1, so a further run follows.
- Reset mid-run or mid-drain: FIFO contents are discarded, and the FSM returns to IDLE with reset values.

Optional Feature:
FOREX_IRQ_EN
- Defined: irq = done_sticky && irq_mask, registered (1 cycle after done_sticky sets). Cleared via control bit2.
- Undefined: irq tied 0. Control bit3 is ignored and reads 0.

Test Plan:
- Default parameters. Write addr0=0x23, then addr1=0xFFFFFF38 with upd_ready=1 -> one cycle of upd_valid with src=2, dst=3, w=0xFFFFFF38. FSM returns to IDLE, no eng_reset, run_count=0.
- upd_ready=0. Push 9 updates into DEPTH=8 -> status count=8, full=1, overflow=1. Release ready -> exactly 8 updates emerge in write order. Write addr2=0x4 -> overflow=0.
- auto_run=1, push 3 updates, hold upd_ready high -> 3 pops, then a single-cycle eng_reset. Pulse eng_done after 10 cycles -> run_count=1, done_sticky=1, busy=0.
- During RUN push 2 updates -> upd_valid stays 0 until eng_done, then both drain and, with auto_run=1, a second eng_reset follows. run_count=2 after the second eng_done.
- auto_run=0, write addr2=0x2 with FIFO empty -> IDLE to RESTART to RUN. eng_done pulsed outside RUN -> run_count unchanged.
- FOREX_IRQ_EN defined, irq_mask=1: run completes -> irq=1 one cycle after done_sticky. Write addr2=0xC -> irq=0. Reset asserted mid-DRAIN -> count=0, upd_valid=0.
